// File: rtl/hist_uart_dump.sv
// Purpose: walk the histogram RAM (port B) and send sync A5 5A plus every bin MSB-first as 8N1 UART.
// Latency: tx start bit on the edge that samples start; done one cycle after the last stop bit completes.
// Backpressure: none; start is honoured only in IDLE, bins are prefetched a byte ahead so bytes never gap.
module hist_uart_dump #(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 1024,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [$clog2(DEPTH)-1:0] addr_b,
  input  logic [WIDTH-1:0]         dout_b,
  output logic                     tx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_MAX  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] BIN_LAST = AW'(DEPTH - 1);
  localparam logic [7:0]    SYNC0_B  = 8'hA5;
  localparam logic [7:0]    SYNC1_B  = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC0  = 3'd1,
    SYNC1  = 3'd2,
    BIN_HI = 3'd3,
    BIN_LO = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   bit_tmr;
  logic [3:0]      bit_cnt;
  logic [AW-1:0]   bin_cnt;
  logic [15:0]     hold;
  logic [15:0]     hold_ext;
  logic [7:0]      shreg;
  logic [7:0]      load_byte;
  logic            fetch_s1;
  logic            fetch_s2;
  logic            in_byte;
  logic            bit_end;
  logic            byte_end;
  logic            byte_load;
  logic            last_bin;

  assign in_byte  = (state == SYNC0) || (state == SYNC1) || (state == BIN_HI) || (state == BIN_LO);
  assign bit_end  = in_byte && (bit_tmr == TMR_MAX);
  assign byte_end = bit_end && (bit_cnt == 4'd9);
  assign last_bin = (bin_cnt == BIN_LAST);
  assign busy     = in_byte;
  assign done     = (state == FINISH);

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: bytes advance only when their stop bit finishes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SYNC0;
      SYNC0:   if (byte_end) state_nxt = SYNC1;
      SYNC1:   if (byte_end) state_nxt = BIN_HI;
      BIN_HI:  if (byte_end) state_nxt = BIN_LO;
      BIN_LO:  if (byte_end) state_nxt = last_bin ? FINISH : BIN_HI;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte about to start, picked by the state being entered; hold is never touched mid-byte
  always_comb begin
    load_byte = 8'h00;
    byte_load = 1'b0;
    hold_ext  = 16'h0000;
    hold_ext[WIDTH-1:0] = dout_b;
    case (state_nxt)
      SYNC0:   load_byte = SYNC0_B;
      SYNC1:   load_byte = SYNC1_B;
      BIN_HI:  load_byte = hold[15:8];
      BIN_LO:  load_byte = hold[7:0];
      default: load_byte = 8'h00;
    endcase
    if (state_nxt != state && state_nxt != IDLE && state_nxt != FINISH) begin
      byte_load = 1'b1;
    end
  end

  // Bit timer, bit counter and serialiser; tx is a flop so the line never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_tmr <= '0;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
    end else if (byte_load) begin
      bit_tmr <= '0;
      bit_cnt <= 4'd0;
      shreg   <= load_byte;
      tx      <= 1'b0;
    end else if (in_byte) begin
      if (bit_end) begin
        bit_tmr <= '0;
        if (bit_cnt <= 4'd7) begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
        end else if (bit_cnt == 4'd8) begin
          bit_cnt <= 4'd9;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= 4'd0;
          tx      <= 1'b1;
        end
      end else begin
        bit_tmr <= bit_tmr + TW'(1);
      end
    end else begin
      bit_tmr <= '0;
      bit_cnt <= 4'd0;
      tx      <= 1'b1;
    end
  end

  // Prefetch: drive addr_b on entry to SYNC0 / BIN_LO, capture dout_b two edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_b   <= '0;
      bin_cnt  <= '0;
      hold     <= 16'h0000;
      fetch_s1 <= 1'b0;
      fetch_s2 <= 1'b0;
    end else begin
      fetch_s1 <= 1'b0;
      fetch_s2 <= fetch_s1;
      if (fetch_s2) begin
        hold <= hold_ext;
      end
      if (state == IDLE && state_nxt == SYNC0) begin
        addr_b   <= '0;
        bin_cnt  <= '0;
        fetch_s1 <= 1'b1;
      end
      if (state == BIN_HI && state_nxt == BIN_LO && !last_bin) begin
        addr_b   <= bin_cnt + AW'(1);
        fetch_s1 <= 1'b1;
      end
      if (state == BIN_LO && state_nxt == BIN_HI) begin
        bin_cnt <= bin_cnt + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hist_uart_dump.sv
// Bench for hist_uart_dump: random bin contents, UART decoder feeding a byte scoreboard,
// plus a cycle-level frame-timing model for busy/done/tx idle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_hist_uart_dump;
  localparam int D     = 4;
  localparam int CPB   = 4;
  localparam int FRAME = (2 + 2 * D) * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [1:0]  addr_b;
  logic [15:0] dout_b;
  logic        tx, busy, done;

  logic [15:0] mem [D];

  int tests = 0;
  int fails = 0;

  hist_uart_dump #(.WIDTH(16), .DEPTH(D), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_b(addr_b),
    .dout_b(dout_b), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous RAM port B
  always @(posedge clk) dout_b <= mem[addr_b];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame timeline + expected bytes ----------------
  int         e = 0;
  int         fs = -1000000;
  bit         m_act = 1'b0;
  bit         exp_busy = 1'b0;
  bit         exp_done = 1'b0;
  logic [7:0] exp_q [$];

  always @(posedge clk) begin
    e++;
    if (!rst) begin
      m_act = 1'b0;
    end else if (start && (!m_act || (e - fs) >= FRAME + 2)) begin
      fs    = e;
      m_act = 1'b1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      for (int n = 0; n < D; n++) begin
        exp_q.push_back(mem[n][15:8]);
        exp_q.push_back(mem[n][7:0]);
      end
    end
    exp_busy = m_act && ((e - fs) < FRAME);
    exp_done = m_act && ((e - fs) == FRAME);
  end

  always @(negedge rst) begin
    m_act    = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_q.delete();
  end

  // ---------------- per-cycle status checks + bit-interval check ----------------
  logic last_tx = 1'b1;
  int   last_e  = 0;
  int   last_fs = -1;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr_b", addr_b, 0);
      last_tx = 1'b1;
      last_fs = -1;
    end else begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (!exp_busy) chk("tx_idle", tx, 1);
      if (tx !== last_tx) begin
        if (m_act && last_fs == fs) chk("bit_interval_mod", (e - last_e) % CPB, 0);
        last_tx = tx;
        last_e  = e;
        last_fs = m_act ? fs : -1;
      end
    end
  end

  // ---------------- UART decoder / scoreboard pop ----------------
  bit         mon_on = 1'b0;
  int         mcyc = 0;
  logic [7:0] sh = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on = 1'b1;
        mcyc   = 0;
      end
    end else begin
      mcyc++;
      if (mcyc % CPB == CPB / 2) begin
        int b;
        b = mcyc / CPB;
        if (b >= 1 && b <= 8) begin
          sh[b-1] = tx;
        end else if (b == 9) begin
          chk("stop_bit", tx, 1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL byte_unexpected: got %0h expected none", sh);
          end else begin
            chk("byte", sh, exp_q.pop_front());
          end
          mon_on = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic rand_mem();
    for (int n = 0; n < D; n++) mem[n] = 16'($urandom);
  endtask

  initial begin
    mem[0] = 16'h0001; mem[1] = 16'h1234; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
    rst = 1'b1;
    #1 rst = 1'b0;
    // reset held with start toggling
    for (int i = 0; i < 10; i++) @(negedge clk) start = ~start;
    @(negedge clk) begin start = 1'b0; rst = 1'b1; end
    repeat (3) @(negedge clk);

    // single frame with fixed bins
    pulse_start();
    repeat (FRAME + 10) @(negedge clk);
    chk("frame1_drained", exp_q.size(), 0);

    // start while busy is ignored
    rand_mem();
    pulse_start();
    repeat (150) @(negedge clk);
    pulse_start();
    repeat (FRAME) @(negedge clk);
    chk("busy_start_drained", exp_q.size(), 0);

    // reset during BIN_HI of bin 2 (byte 6 spans cycles 240..279 of the frame)
    pulse_start();
    repeat (245) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rand_mem();
    pulse_start();
    repeat (FRAME + 10) @(negedge clk);
    chk("post_rst_drained", exp_q.size(), 0);

    // random frames with random gaps
    for (int f = 0; f < 4; f++) begin
      rand_mem();
      repeat ($urandom_range(1, 20)) @(negedge clk);
      pulse_start();
      repeat (FRAME + 5) @(negedge clk);
    end
    chk("random_drained", exp_q.size(), 0);

    // start held high: two back-to-back frames
    rand_mem();
    @(negedge clk) start = 1'b1;
    repeat (FRAME + 5) @(negedge clk);
    start = 1'b0;
    repeat (FRAME + 10) @(negedge clk);
    chk("held_start_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
